// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: first-word-fall-through read port,
// occupancy/watermark reporting and a sticky overflow flag with saturating drop counter.
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    // rd_valid depends only on registered count, so there is no rd_ready -> rd_valid path.
    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

    assign full = (count == FULL_LVL);
    assign pop  = rd_valid & rd_ready;
    assign push = rx_valid & (~full | pop);
    assign drop = rx_valid & full & ~pop;

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: the storage array is deliberately left out of reset; rd_data is masked while
    // empty, so stale contents are never observable and the array can map to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so all registers update
    // from the same pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // Registered from count_next so the flag always agrees with count in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_next >= AF_LVL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // A drop coinciding with a clear restarts the count at one rather than zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 8'h00;
        end else if (drop) begin
            if (ovf_clr) begin
                drop_cnt <= 8'h01;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'h01;
            end
        end else if (ovf_clr) begin
            drop_cnt <= 8'h00;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: the stimulus queues accepted bytes, a negedge monitor
// pops and compares them at every handshake, and a reference model checks status each cycle.
module tb_uart_rx_fifo;

    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] count;
    logic       almost_full;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       ovf_clr;

    uart_rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb [$];
    logic [7:0] last_pop = 8'h00;
    int         m_count  = 0;
    bit         m_ovf    = 1'b0;
    int         m_dc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes the expected byte whenever the DUT completes a read handshake.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got %0h expected no data at %0t", rd_data, $time);
            end else begin
                check("pop_data", {24'h0, rd_data}, {24'h0, sb.pop_front()});
            end
            last_pop = rd_data;
        end
    end

    // One clock of stimulus; the model predicts the post-edge state and it is checked.
    task automatic step(input logic v, input logic [7:0] d, input logic rdy,
                        input logic clr, input logic r);
        bit pop_m, push_m, drop_m;
        rx_valid = v;
        rx_data  = d;
        rd_ready = rdy;
        ovf_clr  = clr;
        rst      = r;
        pop_m  = (m_count != 0) && rdy;
        push_m = v && ((m_count < DEPTH) || pop_m);
        drop_m = v && (m_count == DEPTH) && !pop_m;
        if (!r && push_m) sb.push_back(d);
        @(posedge clk);
        #1;
        if (r) begin
            m_count = 0;
            m_ovf   = 1'b0;
            m_dc    = 0;
            sb.delete();
        end else begin
            if (pop_m && !push_m) m_count--;
            else if (push_m && !pop_m) m_count++;
            if (drop_m) begin
                m_ovf = 1'b1;
                m_dc  = clr ? 1 : ((m_dc == 255) ? 255 : m_dc + 1);
            end else if (clr) begin
                m_ovf = 1'b0;
                m_dc  = 0;
            end
        end
        check("count", {27'h0, count}, m_count);
        check("rd_valid", {31'h0, rd_valid}, {31'h0, m_count != 0});
        check("almost_full", {31'h0, almost_full}, {31'h0, m_count >= AF_LEVEL});
        check("overflow", {31'h0, overflow}, {31'h0, m_ovf});
        check("drop_cnt", {24'h0, drop_cnt}, m_dc);
        if (m_count == 0) check("rd_data_empty", {24'h0, rd_data}, 32'h0);
        else check("rd_data_head", {24'h0, rd_data}, {24'h0, sb[0]});
        rx_valid = 1'b0;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && m_count != 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("drained_count", {27'h0, count}, 32'h0);
        check("scoreboard_empty", sb.size(), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rd_ready = 1'b0; ovf_clr = 1'b0;

        // Reset state, single push/pop.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("reset_af", {31'h0, almost_full}, 32'h0);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        check("a5_visible", {24'h0, rd_data}, 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("a5_gone", {24'h0, rd_data}, 32'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Fill to full with rd_ready low, watermark edges covered by per-cycle checks.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check("full_count", {27'h0, count}, 32'd16);
        check("full_no_ovf", {31'h0, overflow}, 32'h0);
        drain();

        // Overflow and saturation of the drop counter.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        check("drop_one", {24'h0, drop_cnt}, 32'd1);
        for (int i = 0; i < 300; i++) step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        check("drop_sat", {24'h0, drop_cnt}, 32'hFF);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("clr_ovf", {31'h0, overflow}, 32'h0);

        // Push while full with simultaneous pop reuses the freed slot.
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check("swap_count", {27'h0, count}, 32'd16);
        check("swap_no_ovf", {31'h0, overflow}, 32'h0);
        drain();
        check("swap_last", {24'h0, last_pop}, 32'h77);

        // Random interleave across pointer wrap.
        sent = 0;
        for (int cyc = 0; cyc < 2000 && sent < 40; cyc++) begin
            bit v, rdy;
            v   = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            if (v && (m_count < DEPTH || (m_count != 0 && rdy))) begin
                step(1'b1, 8'h40 + 8'(sent), rdy, 1'b0, 1'b0);
                sent++;
            end else begin
                step(1'b0, 8'h00, rdy, 1'b0, 1'b0);
            end
        end
        check("random_sent", sent, 32'd40);
        drain();

        // Reset during simultaneous push+pop at count 9.
        for (int i = 0; i < 9; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
        check("rst_count", {27'h0, count}, 32'h0);
        check("rst_valid", {31'h0, rd_valid}, 32'h0);

        // Clear coincident with a drop: the drop wins.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hDD, 1'b0, 1'b1, 1'b0);
        check("clr_drop_ovf", {31'h0, overflow}, 32'h1);
        check("clr_drop_cnt", {24'h0, drop_cnt}, 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. Each single-cycle data_valid strobe from the receiver pushes one byte. The block presents buffered bytes to the consumer over a first-word-fall-through valid/ready interface. It reports occupancy, an almost-full watermark, a sticky overflow flag and a saturating count of dropped bytes.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
rx_data  input  8  byte from the UART receiver's data_out
rx_valid  input  1  one-cycle push strobe from the receiver's data_valid
rd_data  output  8  head-of-queue byte; 8'h00 whenever rd_valid=0
rd_valid  output  1  queue non-empty; head byte is on rd_data
rd_ready  input  1  consumer accepts the head byte when rd_valid=1 and rd_ready=1
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  output  1  count >= AF_LEVEL
overflow  output  1  sticky; set when a push is dropped
drop_cnt  output  8  dropped-byte counter, saturates at 8'hFF
ovf_clr  input  1  clears overflow and drop_cnt

Behaviour:
- Reset (rst=1 at a clock edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0, drop_cnt=0. Outputs read rd_valid=0, rd_data=8'h00, almost_full=0. Storage array is not reset. rst has priority over all other inputs, including during simultaneous push/pop.
- Storage: DEPTH x 8 register array with no read latency. rd_data = mem[rd_ptr] when count!=0, else 8'h00.
- pop = rd_valid & rd_ready. rd_ready while empty is ignored: no pointer change, no underflow state.
- push = rx_valid & (count<DEPTH | pop). A push while full is accepted only when a pop occurs in the same cycle; the freed slot is reused.
- drop = rx_valid & count==DEPTH & ~pop.
  - The byte is discarded.
  - overflow <= 1.
  - drop_cnt <= drop_cnt+1, saturating at 255.
  - Storage, pointers and count are unchanged.
- Push: mem[wr_ptr] <= rx_data; wr_ptr <= wr_ptr+1 modulo DEPTH, natural wrap from the power-of-two width.
- Pop: rd_ptr <= rd_ptr+1 modulo DEPTH.
- Count update:
  - push only: count+1
  - pop only: count-1
  - both or neither: unchanged
- Empty with push: the pop is impossible in that cycle. The byte written at edge N gives rd_valid=1 and rd_data=that byte after edge N; push-to-visible latency is 1 clock.
- Pop consumption: a byte popped at edge N is gone after edge N; the next byte, if any, appears on rd_data in the same cycle.
- almost_full is a registered compare of the next count against AF_LEVEL, so it is always consistent with count in the same cycle.
- ovf_clr at an edge: overflow <= 0 and drop_cnt <= 0, unless a drop occurs in the same cycle. In that case overflow <= 1 and drop_cnt <= 1; the new drop wins.
- ovf_clr does not affect queue contents, pointers or count.
- Ordering is strict FIFO; no reordering or duplication under any combination of push/pop/drop/clear.
- rx_valid is treated as a level sample each clock. A strobe held high for k cycles produces k pushes; the upstream receiver guarantees 1-cycle pulses.
- The block is a single always-block-per-register design: no state machine beyond pointer/count/flag registers, and no combinational path from rd_ready to rd_valid.

Test Plan:
- Reset then push 8'hA5: rd_valid=1, rd_data=8'hA5 and count=1 one clock later. Pop with rd_ready=1: rd_valid=0, rd_data=8'h00, count=0.
- Push 16 bytes 8'h00..8'h0F with rd_ready=0 (DEPTH=16):
  - count=16
  - almost_full rises on the edge where count reaches 12
  - overflow=0
  - drain returns 8'h00..8'h0F in order; almost_full falls when count reaches 11
- Fill to 16, push 8'hEE without pop: overflow=1, drop_cnt=1, count=16, and 8'hEE never appears on drain. Push 300 more without pop: drop_cnt=255, no wrap.
- At full, rx_valid=1 with 8'h77 and rd_ready=1 in the same cycle: old head popped, 8'h77 stored, count stays 16, overflow stays 0. Drained sequence ends with 8'h77.
- Pointer wrap: push/pop 40 bytes interleaved with random rd_ready (occupancy 0..16). Output sequence equals input sequence, and count matches a scoreboard each cycle.
- Mid-operation reset and clear:
  - assert rst with count=9 and a simultaneous push+pop: count=0, rd_valid=0, overflow=0 next cycle
  - ovf_clr coincident with a drop: overflow=1, drop_cnt=1
